// File: rtl/uart_rx_word_buf_if.sv
// Byte-stream input, FIFO read port and status outputs of the UART word buffer.
interface uart_rx_word_buf_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic [7:0]          rdata;
   logic                rdata_ready;
   logic                ferr;
   logic                flush;
   logic                rd_en;
   logic [31:0]         rd_data;
   logic                rd_valid;
   logic [DEPTH_LOG2:0] count;
   logic                overflow;
   logic [7:0]          ferr_cnt;

   modport master (
      output rdata, rdata_ready, ferr, flush, rd_en,
      input  rd_data, rd_valid, count, overflow, ferr_cnt
   );

   modport slave (
      input  rdata, rdata_ready, ferr, flush, rd_en,
      output rd_data, rd_valid, count, overflow, ferr_cnt
   );
endinterface

// File: rtl/uart_rx_word_buf.sv
// Packs UART bytes little-endian into 32-bit words and queues them in a
// show-ahead FIFO. Also tracks framing errors and dropped words.
//
// state | meaning
// B0    | waiting for byte 0 (bits 7:0)
// B1    | waiting for byte 1 (bits 15:8)
// B2    | waiting for byte 2 (bits 23:16)
// B3    | waiting for byte 3; its strobe completes and pushes the word
//
// DEPTH_LOG2 must be at least 2.
module uart_rx_word_buf #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_rx_word_buf_if.slave    bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {B0, B1, B2, B3} asm_state_t;

   asm_state_t            state_q, state_d;
   logic [23:0]           partial_q, partial_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic [7:0]            ferr_cnt_q, ferr_cnt_d;
   logic [31:0]           mem_q [DEPTH];

   logic        good_byte;
   logic        bad_byte;
   logic        push_req;
   logic        push_ok;
   logic        pop;
   logic        full;
   logic        not_empty;
   logic [31:0] push_word;

   assign not_empty = (count_q != '0);
   assign full      = (count_q == FULL_CNT);
   assign good_byte = bus.rdata_ready & ~bus.ferr & ~bus.flush;
   assign bad_byte  = bus.rdata_ready &  bus.ferr & ~bus.flush;
   assign push_req  = good_byte & (state_q == B3);
   assign pop       = bus.rd_en & not_empty & ~bus.flush;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
   assign push_ok   = push_req & (~full | pop);
   assign push_word = {bus.rdata, partial_q};

   // Assembly state and all FIFO bookkeeping registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= B0;
         partial_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         ferr_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         partial_q  <= partial_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         ferr_cnt_q <= ferr_cnt_d;
      end
   end

   // Next-state: byte assembly, error resync, pointer/count update and flush.
   always_comb begin
      state_d    = state_q;
      partial_d  = partial_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      ferr_cnt_d = ferr_cnt_q;

      if (bus.flush) begin
         state_d    = B0;
         partial_d  = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (bad_byte) begin
            state_d   = B0;
            partial_d = '0;
            if (ferr_cnt_q != 8'hFF) begin
               ferr_cnt_d = ferr_cnt_q + 8'd1;
            end
         end else if (good_byte) begin
            unique case (state_q)
               B0: begin
                  partial_d[7:0] = bus.rdata;
                  state_d        = B1;
               end
               B1: begin
                  partial_d[15:8] = bus.rdata;
                  state_d         = B2;
               end
               B2: begin
                  partial_d[23:16] = bus.rdata;
                  state_d          = B3;
               end
               B3: begin
                  partial_d = '0;
                  state_d   = B0;
               end
               default: state_d = B0;
            endcase
         end

         if (push_req & ~push_ok) begin
            overflow_d = 1'b1;
         end
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         if (push_ok && !pop) begin
            count_d = count_q + CNT_ONE;
         end else if (pop && !push_ok) begin
            count_d = count_q - CNT_ONE;
         end
      end
   end

   // Storage is not reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_word;
      end
   end

   assign bus.rd_valid = not_empty;
   assign bus.rd_data  = not_empty ? mem_q[rd_ptr_q] : 32'h0;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;
   assign bus.ferr_cnt = ferr_cnt_q;

endmodule

// File: doc/uart_rx_word_buf.md
Name: uart_rx_word_buf

Overview:
Downstream consumer of the UART receiver byte stream. It packs received bytes little-endian into 32-bit words and buffers them in a show-ahead FIFO. The core's program loader and input instructions pop words from the FIFO. It also counts framing errors and flags overflow so host-side loader faults are visible.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth in 32-bit words (default 16 entries)

Ports:
clk  input  1  system clock, same domain as the UART receiver
rst  input  1  asynchronous, active-high reset
rdata  input  8  received byte from the UART receiver
rdata_ready  input  1  one-cycle strobe; rdata/ferr valid this cycle
ferr  input  1  framing error for the byte strobed this cycle (coincident with rdata_ready)
flush  input  1  synchronous clear of partial word, FIFO and overflow flag
rd_en  input  1  pop request from consumer
rd_data  output  32  head word of FIFO (valid when rd_valid=1)
rd_valid  output  1  FIFO non-empty
count  output  DEPTH_LOG2+1  number of words stored
overflow  output  1  sticky; a completed word was dropped because the FIFO was full
ferr_cnt  output  8  saturating count of framing-error bytes

Behaviour:
- Reset (async, rst=1): byte_idx=0, partial word=0, wr/rd pointers=0, count=0, rd_valid=0, rd_data don't-care (drive 0 acceptable), overflow=0, ferr_cnt=0. FIFO RAM contents are not reset.
- Assembly states are held in byte_idx (B0..B3), a 2-bit counter.
  - On rdata_ready=1 and ferr=0 at byte_idx=k (k<3): store rdata into partial[8k+7:8k], byte_idx <= k+1.
  - At B3 with rdata_ready=1 and ferr=0: word = {rdata, partial[23:0]} is pushed at this edge, byte_idx <= 0.
  - Byte order: first received byte goes to bits 7:0.
- Framing error (rdata_ready=1 and ferr=1): the byte is discarded, byte_idx <= 0, partial <= 0 (resync to word boundary), and ferr_cnt <= ferr_cnt+1, saturating at 255.
- ferr=1 without rdata_ready is ignored.
- Push latency:
  - The word is written on the edge where the 4th byte strobe is sampled.
  - count and rd_valid update on that same edge, so rd_valid is high the cycle after the strobe.
- FIFO organisation:
  - Circular buffer of 2^DEPTH_LOG2 entries.
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - count is the full/empty discriminator: full when count==2^DEPTH_LOG2, empty when count==0.
- Read (show-ahead):
  - rd_data is the entry at rd_ptr, read combinationally (distributed RAM).
  - rd_en=1 and rd_valid=1: pop at the edge, rd_ptr+1, count-1.
  - rd_en=1 while empty: ignored, no pointer or count change.
- Simultaneous push and pop:
  - Both occur and count is unchanged. This holds when full: the pop frees the slot, the push is accepted, and there is no overflow.
  - When empty, push with rd_en=1: the pop is ignored (rd_valid was 0) and count becomes 1.
- Overflow:
  - A push when full with no pop drops the word: no pointer or count change, and overflow <= 1.
  - overflow is sticky until rst or flush.
- flush=1 (synchronous):
  - byte_idx=0, partial=0, pointers=0, count=0, overflow=0.
  - ferr_cnt is kept.
  - flush has priority over a push or pop in the same cycle; a byte strobed in the flush cycle is discarded.
- Reset mid-operation: a partial word and all FIFO contents are lost; the consumer sees rd_valid=0 immediately (async).
- The block is purely synchronous to clk. rdata_ready is a single-cycle strobe, so each strobe is counted once.

Test Plan:
- Bytes 0x78,0x56,0x34,0x12 strobed with gaps -> one cycle after 4th strobe rd_valid=1, rd_data=0x12345678, count=1; rd_en for one cycle -> rd_valid=0, count=0.
- Bytes 0xAA,0xBB, then a strobe with ferr=1, then 0x01,0x02,0x03,0x04 -> ferr_cnt=1, single word 0x04030201, no word containing 0xAA/0xBB.
- With DEPTH_LOG2=2, push 5 words (values 0..4 in byte 0) without popping -> count=4, overflow=1, pops return 0,1,2,3 in order, then rd_valid=0.
- FIFO full; 4th byte strobe coincident with rd_en -> count stays 4, overflow stays 0, and after draining the last word read is the new one.
- Partial word of 2 bytes, then flush=1 -> count=0, overflow=0, ferr_cnt unchanged; next 4 bytes 0x11,0x22,0x33,0x44 give 0x44332211.
- 300 ferr strobes -> ferr_cnt saturates at 255; assert rst mid-word -> all outputs return to reset values asynchronously.
